adc128s_spi_model: RTL and testbench
====================================

Name: adc128s_spi_model

Overview:
Synthesizable behavioural model of the DE0 board's ADC128S 8-channel A2D converter, acting as an SPI slave on the A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO bus. It sits directly downstream of the Segway DUT's A2D interface in the full-chip testbench. It returns the stimulus values ld_cell_lft (ch0), ld_cell_rght (ch4) and batt_V (ch5) with real-device framing and one-frame channel pipelining.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer chain (SCLK, SS_n, MOSI); minimum 2.
UNUSED_VAL, 12'h000, result returned for channels 1,2,3,6,7.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
SS_n  in  1  SPI slave select, active low.
SCLK  in  1  SPI clock; idles high.
MOSI  in  1  master data.
MISO  out  1  slave data.
ld_cell_lft  in  12  channel 0 value.
ld_cell_rght  in  12  channel 4 value.
batt_V  in  12  channel 5 value.
frame_cnt  out  8  count of completed 16-bit frames; wraps 255->0.
last_chnl  out  3  channel address captured in the most recent completed frame.

Behaviour:
- Reset: as already decided, one clock (clk); reset is synchronous and active-high (rst). On reset: MISO=1, frame_cnt=0, last_chnl=0, pending channel=0, bit counter=0, state=IDLE. Reset mid-frame aborts the frame with no counter update.
- Inputs pass through SYNC_STAGES flops plus one edge-detect flop. Edge latency is SYNC_STAGES+1 clk. The master must hold SCLK high/low for at least SYNC_STAGES+2 clk.
- SPI mode: SCLK idles high. The master changes MOSI on SCLK fall. The slave samples MOSI on synchronized SCLK rise and shifts MISO on synchronized SCLK fall.
- FSM states:
  - IDLE: MISO=1. On SS_n fall, load shift_tx = {4'b0000, value(pending channel)}, clear bit_cnt, and go to SHIFT. Channel values are snapshotted at this point; later input changes do not affect the frame in flight.
  - SHIFT: MISO = shift_tx[15] from SS_n fall onward.
    - Each SCLK rise: shift MOSI into shift_rx and increment bit_cnt.
    - Each SCLK fall after at least one rise: shift_tx left by one, filling 0.
    - When bit_cnt reaches 16, go to DONE.
  - DONE: extra SCLK edges are ignored and MISO=0. On SS_n rise: pending channel = shift_rx[13:11], last_chnl = shift_rx[13:11], frame_cnt++, go to IDLE.
- SS_n rise while in SHIFT (fewer than 16 rises) aborts the frame: pending channel and counters are unchanged, and the FSM returns to IDLE.
- Channel map: 0 -> ld_cell_lft, 4 -> ld_cell_rght, 5 -> batt_V, all others -> UNUSED_VAL.
- Pipelining: the data returned in frame N is for the channel addressed in frame N-1. The first frame after reset returns channel 0.
- Bits of shift_rx other than [13:11] are don't-care.
- SCLK activity while SS_n is high is ignored.

Decomposition:
- Package a2d_pkg:
  - constants CH_LFT=3'd0, CH_RGHT=3'd4, CH_BATT=3'd5, FRAME_BITS=16;
  - typedef enum logic[1:0] {IDLE, SHIFT, DONE} adc_state_t.
- Sub-module spi_edge_sync (params SYNC_STAGES): synchronizer chain plus rise/fall pulse outputs. Instantiate it for SCLK and SS_n; MOSI uses the synchronizer only.

Test Plan:
- Reset, then ld_cell_lft=12'h3A5. Frame 1 with cmd 16'h0000 -> MISO returns 16'h03A5; frame_cnt=1, last_chnl=0.
- Frame with cmd 16'h2000 (ch4) while ld_cell_rght=12'h7FF, then a second frame with cmd 16'h2800 (ch5), batt_V=12'hC00 -> second frame returns 16'h07FF; third frame returns 16'h0C00.
- Address ch2 (cmd 16'h1000), then frame -> returns 16'h0000 (UNUSED_VAL); last_chnl=2.
- Raise SS_n after 9 SCLK rises while addressing ch5 -> frame_cnt unchanged; next frame still returns the previously pending channel; MISO=1 while idle.
- Change batt_V from 12'h800 to 12'h123 mid-frame -> the frame in flight returns 12'h800; the following ch5 frame returns 12'h123.
- Assert rst during bit 7 of a ch4 frame -> MISO=1, frame_cnt=0; the next frame returns the ch0 value. Separately, run 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/a2d_pkg.sv
// Shared constants, state encoding and channel-map helper for the ADC128S
// SPI slave model.
package a2d_pkg;

    // Channel addresses that carry live stimulus values.
    localparam logic [2:0] CH_LFT  = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_BATT = 3'd5;

    // One conversion frame is 16 SCLK periods.
    localparam int FRAME_BITS = 16;

    // Bit counter must hold 0..FRAME_BITS inclusive.
    localparam int BIT_CNT_W = $clog2(FRAME_BITS + 1);

    // Count value at which the next SCLK rise completes the frame.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } adc_state_t;

    // Maps a channel address to the 12-bit result the converter returns.
    function automatic logic [11:0] chnl_value(
        input logic [2:0]  i_chnl,
        input logic [11:0] i_lft,
        input logic [11:0] i_rght,
        input logic [11:0] i_batt,
        input logic [11:0] i_unused
    );
        logic [11:0] w_val;
        case (i_chnl)
            CH_LFT:  w_val = i_lft;
            CH_RGHT: w_val = i_rght;
            CH_BATT: w_val = i_batt;
            default: w_val = i_unused;
        endcase
        return w_val;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous SPI line, followed by an
// edge-detect flop that produces one-clk rise/fall pulses. An input change
// is acted on SYNC_STAGES+1 clk edges after it occurs. SYNC_STAGES must be
// at least 2.
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync;

    // Synchronizer chain plus the previous-value flop for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and the chain really delays by one stage each.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= w_sync;
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = w_sync & ~r_prev;
    assign o_fall = ~w_sync & r_prev;

endmodule

// File: rtl/adc128s_spi_model.sv
// Behavioural, synthesizable model of the ADC128S 8-channel converter as an
// SPI slave. Each 16-bit frame returns {4'b0000, value} for the channel that
// was addressed in the previous frame. The address for the next frame is
// taken from MOSI bits [13:11] of the current frame.
module adc128s_spi_model
    import a2d_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] UNUSED_VAL  = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] ld_cell_lft,
    input  logic [11:0] ld_cell_rght,
    input  logic [11:0] batt_V,
    output logic [7:0]  frame_cnt,
    output logic [2:0]  last_chnl
);

    // Synchronized bus events.
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_rise;
    logic w_ss_fall;
    logic w_mosi;

    // FSM.
    adc_state_t r_state;
    adc_state_t w_state_nxt;

    // Datapath strobes decoded by the FSM.
    logic w_load;
    logic w_sample;
    logic w_shift;
    logic w_commit;

    // Datapath registers.
    logic [15:0]          r_shift_tx;
    // Only bits [13:11] of the received command matter; older bits fall off
    // the top of this shorter register.
    logic [13:0]          r_shift_rx;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [2:0]           r_pending;
    logic [2:0]           r_last_chnl;
    logic [7:0]           r_frame_cnt;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    // SCLK idles high, so its synchronizer resets high to avoid a false fall.
    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sclk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (SCLK),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // SS_n idles high, so its synchronizer resets high as well.
    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_ss_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (SS_n),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    // MOSI only needs a level synchronizer; it is stable around SCLK rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath strobes and MISO drive.
    // NOTE: every output of this block gets a default first so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_sample    = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        MISO        = 1'b1;

        case (r_state)
            IDLE: begin
                MISO = 1'b1;
                if (w_ss_fall) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                MISO = r_shift_tx[15];
                if (w_ss_rise) begin
                    // Short frame: abandon it without touching the counters.
                    w_state_nxt = IDLE;
                end else if (w_sclk_rise) begin
                    w_sample = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = DONE;
                    end
                end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                    // The leading fall before the first rise must not shift,
                    // otherwise the MSB would be lost.
                    w_shift = 1'b1;
                end
            end

            DONE: begin
                MISO = 1'b0;
                if (w_ss_rise) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shift registers, bit counter and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_tx  <= '0;
            r_shift_rx  <= '0;
            r_bit_cnt   <= '0;
            r_pending   <= CH_LFT;
            r_last_chnl <= CH_LFT;
            r_frame_cnt <= '0;
        end else begin
            if (w_load) begin
                // Snapshot the result now; later input changes do not
                // disturb the frame in flight.
                r_shift_tx <= {4'b0000, chnl_value(r_pending, ld_cell_lft,
                                                   ld_cell_rght, batt_V,
                                                   UNUSED_VAL)};
                r_bit_cnt  <= '0;
            end

            if (w_sample) begin
                r_shift_rx <= {r_shift_rx[12:0], w_mosi};
                r_bit_cnt  <= r_bit_cnt + 1'b1;
            end

            if (w_shift) begin
                r_shift_tx <= {r_shift_tx[14:0], 1'b0};
            end

            if (w_commit) begin
                r_pending   <= r_shift_rx[13:11];
                r_last_chnl <= r_shift_rx[13:11];
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign last_chnl = r_last_chnl;

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Self-checking bench for adc128s_spi_model: an SPI master drives directed
// and random frames; a frame-level model predicts replies and counters.
module tb_adc128s_spi_model;

    localparam int SYNC_STAGES = 2;
    // SCLK half period in clk cycles; at least SYNC_STAGES+2.
    localparam int H = SYNC_STAGES + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [11:0] ld_cell_lft;
    logic [11:0] ld_cell_rght;
    logic [11:0] batt_V;
    logic [7:0]  frame_cnt;
    logic [2:0]  last_chnl;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference model state.
    int         m_pending;
    int         m_last;
    logic [7:0] m_cnt;

    always #5 clk = ~clk;

    adc128s_spi_model #(
        .SYNC_STAGES (SYNC_STAGES),
        .UNUSED_VAL  (12'h000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .SS_n         (SS_n),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .ld_cell_lft  (ld_cell_lft),
        .ld_cell_rght (ld_cell_rght),
        .batt_V       (batt_V),
        .frame_cnt    (frame_cnt),
        .last_chnl    (last_chnl)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reply the converter should give for the currently pending channel.
    function automatic logic [15:0] m_reply();
        logic [11:0] tbl [8];
        for (int c = 0; c < 8; c++) tbl[c] = 12'h000;
        tbl[0] = ld_cell_lft;
        tbl[4] = ld_cell_rght;
        tbl[5] = batt_V;
        return {4'h0, tbl[m_pending]};
    endfunction

    task automatic m_reset();
        m_pending = 0;
        m_last    = 0;
        m_cnt     = 8'd0;
    endtask

    // SPI master: n_rises SCLK pulses; optional batt_V change at bit chg_bit.
    task automatic do_frame(input logic [15:0] cmd, input int n_rises, input bit raise_ss,
                            input int chg_bit, input logic [11:0] chg_val,
                            output logic [15:0] rx);
        rx   = 16'h0000;
        SS_n = 1'b0;
        wait_clk(H);
        for (int i = 0; i < n_rises; i++) begin
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            if (i == chg_bit) batt_V = chg_val;
            wait_clk(H);
            rx[15-i] = MISO;
            SCLK = 1'b1;
            wait_clk(H);
        end
        if (raise_ss) begin
            if (n_rises == 16) check("miso_done", {15'b0, MISO}, 16'h0000);
            SS_n = 1'b1;
            MOSI = 1'b0;
            wait_clk(H + 2);
        end else begin
            SCLK = 1'b0;
            wait_clk(H);
        end
    endtask

    // One frame with model prediction and post-frame checks.
    task automatic run_frame(input string tag, input logic [15:0] cmd, input int n_rises,
                             input int chg_bit, input logic [11:0] chg_val,
                             output logic [15:0] rx);
        logic [15:0] exp;
        int          sh;
        exp = m_reply();
        do_frame(cmd, n_rises, 1'b1, chg_bit, chg_val, rx);
        sh = 16 - n_rises;
        check({tag, "_rx"}, rx >> sh, exp >> sh);
        if (n_rises == 16) begin
            m_pending = int'(cmd[13:11]);
            m_last    = m_pending;
            m_cnt     = m_cnt + 8'd1;
        end
        check({tag, "_cnt"}, {8'h00, frame_cnt}, {8'h00, m_cnt});
        check({tag, "_last"}, {13'h0, last_chnl}, 16'(m_last));
        check({tag, "_idle_miso"}, {15'b0, MISO}, 16'h0001);
    endtask

    // Absolute time bound so the run always ends.
    initial begin
        #(10_000_000);
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rx;
        logic [15:0] cmd;
        logic [2:0]  ch;

        rst          = 1'b1;
        SS_n         = 1'b1;
        SCLK         = 1'b1;
        MOSI         = 1'b0;
        ld_cell_lft  = 12'h000;
        ld_cell_rght = 12'h000;
        batt_V       = 12'h000;
        m_reset();

        // Reset state.
        wait_clk(3);
        check("rst_miso", {15'b0, MISO}, 16'h0001);
        check("rst_cnt", {8'h00, frame_cnt}, 16'h0000);
        check("rst_last", {13'h0, last_chnl}, 16'h0000);
        rst = 1'b0;
        wait_clk(H);

        // First frame after reset returns channel 0.
        ld_cell_lft = 12'h3A5;
        run_frame("f1", 16'h0000, 16, -1, 12'h0, rx);
        check("f1_const", rx, 16'h03A5);

        // Pipelined ch4 then ch5.
        ld_cell_rght = 12'h7FF;
        run_frame("ch4_addr", 16'h2000, 16, -1, 12'h0, rx);
        batt_V = 12'hC00;
        run_frame("ch5_addr", 16'h2800, 16, -1, 12'h0, rx);
        check("ch4_const", rx, 16'h07FF);
        run_frame("ch5_data", 16'h0000, 16, -1, 12'h0, rx);
        check("ch5_const", rx, 16'h0C00);

        // Unused channel 2.
        run_frame("ch2_addr", 16'h1000, 16, -1, 12'h0, rx);
        check("ch2_last", {13'h0, last_chnl}, 16'h0002);
        run_frame("ch2_data", 16'h0000, 16, -1, 12'h0, rx);
        check("ch2_const", rx, 16'h0000);

        // Aborted frame after 9 rises leaves pending channel 4 in place.
        run_frame("pre_abort", 16'h2000, 16, -1, 12'h0, rx);
        run_frame("abort", 16'h2800, 9, -1, 12'h0, rx);
        run_frame("post_abort", 16'h0000, 16, -1, 12'h0, rx);
        check("post_abort_const", rx, {4'h0, ld_cell_rght});

        // Snapshot: batt_V changes mid-frame.
        batt_V = 12'h800;
        run_frame("snap_addr", 16'h2800, 16, -1, 12'h0, rx);
        run_frame("snap_fly", 16'h2800, 16, 4, 12'h123, rx);
        check("snap_fly_const", rx, 16'h0800);
        run_frame("snap_next", 16'h0000, 16, -1, 12'h0, rx);
        check("snap_next_const", rx, 16'h0123);

        // Reset during bit 7 of a ch4 frame.
        run_frame("prerst_addr", 16'h2000, 16, -1, 12'h0, rx);
        do_frame(16'h2000, 7, 1'b0, -1, 12'h0, rx);
        rst  = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b0;
        wait_clk(1);
        check("midrst_miso", {15'b0, MISO}, 16'h0001);
        check("midrst_cnt", {8'h00, frame_cnt}, 16'h0000);
        rst = 1'b0;
        m_reset();
        wait_clk(H);
        run_frame("postrst", 16'h0000, 16, -1, 12'h0, rx);
        check("postrst_const", rx, {4'h0, ld_cell_lft});

        // Random frames against the model.
        for (int k = 0; k < 24; k++) begin
            ld_cell_lft  = 12'($urandom);
            ld_cell_rght = 12'($urandom);
            batt_V       = 12'($urandom);
            case ($urandom_range(0, 3))
                0:       ch = 3'd0;
                1:       ch = 3'd4;
                2:       ch = 3'd5;
                default: ch = 3'($urandom);
            endcase
            cmd = {2'($urandom), ch, 11'($urandom)};
            run_frame("rand", cmd, 16, -1, 12'h0, rx);
        end

        // Frame counter wrap after 256 frames from reset.
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        m_reset();
        wait_clk(H);
        for (int k = 0; k < 256; k++) begin
            cmd = 16'($urandom);
            run_frame("wrap", cmd, 16, -1, 12'h0, rx);
        end
        check("wrap_zero", {8'h00, frame_cnt}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
